// File: rtl/ir_rx_pkg.sv
// Shared constants for the NEC infrared receiver: SFR map, STATUS bit positions,
// default timing windows in 50 MHz clock cycles, and the decoder state encoding.
package ir_rx_pkg;

    localparam logic [7:0] ADDR_STATUS = 8'hE1;
    localparam logic [7:0] ADDR_ADDR   = 8'hE2;
    localparam logic [7:0] ADDR_ADDR_N = 8'hE3;
    localparam logic [7:0] ADDR_CMD    = 8'hE4;
    localparam logic [7:0] ADDR_CMD_N  = 8'hE5;

    localparam int BIT_FRAME_VALID = 0;
    localparam int BIT_REPEAT      = 1;
    localparam int BIT_CSUM_ERR    = 2;
    localparam int BIT_FRAMING_ERR = 3;
    localparam int BIT_OVERRUN     = 4;
    localparam int BIT_IE          = 6;
    localparam int BIT_EN          = 7;

    localparam int unsigned GLITCH_D = 32'd250;

    localparam logic [19:0] LEAD_MARK_MIN_D = 20'd400000;
    localparam logic [19:0] LEAD_MARK_MAX_D = 20'd500000;
    localparam logic [19:0] LEAD_SPC_MIN_D  = 20'd200000;
    localparam logic [19:0] LEAD_SPC_MAX_D  = 20'd250000;
    localparam logic [19:0] REP_SPC_MIN_D   = 20'd100000;
    localparam logic [19:0] REP_SPC_MAX_D   = 20'd125000;
    localparam logic [19:0] BIT_MARK_MIN_D  = 20'd20000;
    localparam logic [19:0] BIT_MARK_MAX_D  = 20'd36000;
    localparam logic [19:0] ZERO_SPC_MIN_D  = 20'd20000;
    localparam logic [19:0] ZERO_SPC_MAX_D  = 20'd36000;
    localparam logic [19:0] ONE_SPC_MIN_D   = 20'd70000;
    localparam logic [19:0] ONE_SPC_MAX_D   = 20'd100000;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_MARK  = 3'd1,
        ST_LEAD_SPACE = 3'd2,
        ST_BIT_MARK   = 3'd3,
        ST_BIT_SPACE  = 3'd4,
        ST_TAIL_MARK  = 3'd5
    } rx_state_e;

    function automatic logic in_win(input logic [19:0] v, input logic [19:0] lo,
                                    input logic [19:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // NEC integrity: each byte must be followed by its bitwise complement.
    function automatic logic csum_ok(input logic [31:0] w);
        return ((w[7:0] ^ w[15:8]) == 8'hFF) && ((w[23:16] ^ w[31:24]) == 8'hFF);
    endfunction

endpackage

// File: rtl/ir_rx_filter.sv
// Input conditioning for the IR line: 2-flop synchronizer, glitch filter that only
// accepts a level held for GLITCH cycles, and one-cycle fall/rise pulses.
module ir_rx_filter
    import ir_rx_pkg::*;
#(
    parameter int unsigned GLITCH = GLITCH_D
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rxd,
    output logic filt,
    output logic fall,
    output logic rise
);

    localparam int unsigned GW = (GLITCH < 32'd2) ? 32'd1 : $clog2(GLITCH);
    localparam logic [GW-1:0] G_LAST = GW'(GLITCH - 32'd1);

    logic [1:0]    sync_r;
    logic [GW-1:0] cnt_r;
    logic          filt_r;
    logic          fall_r;
    logic          rise_r;

    // Synchronize, then flip the filtered level once the new value has persisted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= 2'b11;
            cnt_r  <= '0;
            filt_r <= 1'b1;
            fall_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], rxd};
            fall_r <= 1'b0;
            rise_r <= 1'b0;
            if (sync_r[1] == filt_r) begin
                cnt_r <= '0;
            end else if (cnt_r == G_LAST) begin
                cnt_r  <= '0;
                filt_r <= sync_r[1];
                fall_r <= ~sync_r[1];
                rise_r <= sync_r[1];
            end else begin
                cnt_r <= cnt_r + GW'(1);
            end
        end
    end

    assign filt = filt_r;
    assign fall = fall_r;
    assign rise = rise_r;

endmodule

// File: rtl/ir_rx_ctrl.sv
// NEC infrared receiver: times filtered mark/space widths, decodes leader, repeat and
// 32-bit frames, and exposes results and interrupt status on the 8051 SFR bus.
module ir_rx_ctrl
    import ir_rx_pkg::*;
#(
    parameter int unsigned GLITCH        = GLITCH_D,
    parameter logic [19:0] LEAD_MARK_MIN = LEAD_MARK_MIN_D,
    parameter logic [19:0] LEAD_MARK_MAX = LEAD_MARK_MAX_D,
    parameter logic [19:0] LEAD_SPC_MIN  = LEAD_SPC_MIN_D,
    parameter logic [19:0] LEAD_SPC_MAX  = LEAD_SPC_MAX_D,
    parameter logic [19:0] REP_SPC_MIN   = REP_SPC_MIN_D,
    parameter logic [19:0] REP_SPC_MAX   = REP_SPC_MAX_D,
    parameter logic [19:0] BIT_MARK_MIN  = BIT_MARK_MIN_D,
    parameter logic [19:0] BIT_MARK_MAX  = BIT_MARK_MAX_D,
    parameter logic [19:0] ZERO_SPC_MIN  = ZERO_SPC_MIN_D,
    parameter logic [19:0] ZERO_SPC_MAX  = ZERO_SPC_MAX_D,
    parameter logic [19:0] ONE_SPC_MIN   = ONE_SPC_MIN_D,
    parameter logic [19:0] ONE_SPC_MAX   = ONE_SPC_MAX_D
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sfr_rd,
    input  logic       sfr_wr,
    input  logic [7:0] sfr_addr,
    input  logic [7:0] sfr_data_out,
    output logic [7:0] sfr_data_in,
    input  logic       IRDA_RXD,
    output logic       ir_irq
);

    logic filt_s;
    logic fall_s;
    logic rise_s;
    logic edge_s;

    ir_rx_filter #(.GLITCH(GLITCH)) u_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .rxd     (IRDA_RXD),
        .filt    (filt_s),
        .fall    (fall_s),
        .rise    (rise_s)
    );

    assign edge_s = fall_s | rise_s;

    logic [19:0] cnt_r;

    // Width counter: restarts on every filtered edge and saturates on long levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= 20'd0;
        end else if (edge_s) begin
            cnt_r <= 20'd0;
        end else if (cnt_r != 20'hFFFFF) begin
            cnt_r <= cnt_r + 20'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    rx_state_e   state_r, state_n;
    logic [31:0] shift_r, shift_n;
    logic [4:0]  idx_r, idx_n;
    logic        is_rep_r, is_rep_n;
    logic [4:0]  flags_r, flags_n;
    logic        en_r, en_n;
    logic        ie_r, ie_n;
    logic        irq_r, irq_n;
    logic [7:0]  addr_r, addr_n_r, cmd_r, cmd_n_r;
    logic [4:0]  set_s;
    logic [4:0]  clr_s;
    logic        load_s;

    // Decoder next state; set_s collects the hardware flag events of this cycle.
    always_comb begin
        state_n  = state_r;
        shift_n  = shift_r;
        idx_n    = idx_r;
        is_rep_n = is_rep_r;
        set_s    = 5'd0;
        load_s   = 1'b0;
        if (!en_r) begin
            state_n  = ST_IDLE;
            shift_n  = 32'd0;
            idx_n    = 5'd0;
            is_rep_n = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_n = ST_LEAD_MARK;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_LEAD_MARK: begin
                    if (rise_s && in_win(cnt_r, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                        state_n = ST_LEAD_SPACE;
                    end else if (rise_s || cnt_r > LEAD_MARK_MAX) begin
                        set_s[BIT_FRAMING_ERR] = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_LEAD_MARK;
                    end
                end
                ST_LEAD_SPACE: begin
                    if (fall_s && in_win(cnt_r, LEAD_SPC_MIN, LEAD_SPC_MAX)) begin
                        shift_n = 32'd0;
                        idx_n   = 5'd0;
                        state_n = ST_BIT_MARK;
                    end else if (fall_s && in_win(cnt_r, REP_SPC_MIN, REP_SPC_MAX)) begin
                        is_rep_n = 1'b1;
                        state_n  = ST_TAIL_MARK;
                    end else if (fall_s || cnt_r > LEAD_SPC_MAX) begin
                        set_s[BIT_FRAMING_ERR] = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_LEAD_SPACE;
                    end
                end
                ST_BIT_MARK: begin
                    if (rise_s && in_win(cnt_r, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                        state_n = ST_BIT_SPACE;
                    end else if (rise_s || cnt_r > BIT_MARK_MAX) begin
                        set_s[BIT_FRAMING_ERR] = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_BIT_MARK;
                    end
                end
                ST_BIT_SPACE: begin
                    if (fall_s && (in_win(cnt_r, ZERO_SPC_MIN, ZERO_SPC_MAX) ||
                                   in_win(cnt_r, ONE_SPC_MIN, ONE_SPC_MAX))) begin
                        shift_n = {in_win(cnt_r, ONE_SPC_MIN, ONE_SPC_MAX), shift_r[31:1]};
                        if (idx_r == 5'd31) begin
                            is_rep_n = 1'b0;
                            state_n  = ST_TAIL_MARK;
                        end else begin
                            idx_n   = idx_r + 5'd1;
                            state_n = ST_BIT_MARK;
                        end
                    end else if (fall_s || cnt_r > ONE_SPC_MAX) begin
                        set_s[BIT_FRAMING_ERR] = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_BIT_SPACE;
                    end
                end
                ST_TAIL_MARK: begin
                    if (rise_s && in_win(cnt_r, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                        state_n = ST_IDLE;
                        if (is_rep_r) begin
                            set_s[BIT_REPEAT] = 1'b1;
                        end else if (csum_ok(shift_r)) begin
                            load_s = 1'b1;
                            set_s[BIT_FRAME_VALID] = 1'b1;
                            set_s[BIT_OVERRUN]     = flags_r[BIT_FRAME_VALID];
                        end else begin
                            set_s[BIT_CSUM_ERR] = 1'b1;
                        end
                    end else if (rise_s || cnt_r > BIT_MARK_MAX) begin
                        set_s[BIT_FRAMING_ERR] = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_TAIL_MARK;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // STATUS update: software write-1-to-clear, with a same-cycle hardware set winning.
    always_comb begin
        clr_s = 5'd0;
        en_n  = en_r;
        ie_n  = ie_r;
        if (sfr_wr && sfr_addr == ADDR_STATUS) begin
            clr_s = sfr_data_out[4:0];
            en_n  = sfr_data_out[BIT_EN];
            ie_n  = sfr_data_out[BIT_IE];
        end else begin
            clr_s = 5'd0;
        end
        flags_n = (flags_r & ~clr_s) | set_s;
        irq_n   = ie_n & (flags_n[BIT_FRAME_VALID] | flags_n[BIT_REPEAT]);
    end

    // Decoder, STATUS and data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            shift_r  <= 32'd0;
            idx_r    <= 5'd0;
            is_rep_r <= 1'b0;
            flags_r  <= 5'd0;
            en_r     <= 1'b0;
            ie_r     <= 1'b0;
            irq_r    <= 1'b0;
            addr_r   <= 8'h00;
            addr_n_r <= 8'h00;
            cmd_r    <= 8'h00;
            cmd_n_r  <= 8'h00;
        end else begin
            state_r  <= state_n;
            shift_r  <= shift_n;
            idx_r    <= idx_n;
            is_rep_r <= is_rep_n;
            flags_r  <= flags_n;
            en_r     <= en_n;
            ie_r     <= ie_n;
            irq_r    <= irq_n;
            if (load_s) begin
                addr_r   <= shift_r[7:0];
                addr_n_r <= shift_r[15:8];
                cmd_r    <= shift_r[23:16];
                cmd_n_r  <= shift_r[31:24];
            end
        end
    end

    // CPU read mux; unmapped addresses and idle bus read as zero.
    always_comb begin
        sfr_data_in = 8'h00;
        if (sfr_rd) begin
            case (sfr_addr)
                ADDR_STATUS: sfr_data_in = {en_r, ie_r, 1'b0, flags_r};
                ADDR_ADDR:   sfr_data_in = addr_r;
                ADDR_ADDR_N: sfr_data_in = addr_n_r;
                ADDR_CMD:    sfr_data_in = cmd_r;
                ADDR_CMD_N:  sfr_data_in = cmd_n_r;
                default:     sfr_data_in = 8'h00;
            endcase
        end else begin
            sfr_data_in = 8'h00;
        end
    end

    assign ir_irq = irq_r;

endmodule

// File: tb/tb_ir_rx_ctrl.sv
// Scoreboard bench for ir_rx_ctrl with timing windows scaled by 1/1000 (GLITCH = 4)
// so whole NEC frames fit in a few thousand cycles.
module tb_ir_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sfr_rd = 1'b0;
    logic       sfr_wr = 1'b0;
    logic [7:0] sfr_addr = 8'h00;
    logic [7:0] sfr_data_out = 8'h00;
    logic [7:0] sfr_data_in;
    logic       irda_rxd = 1'b1;
    logic       ir_irq;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       irq;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ir_rx_ctrl #(
        .GLITCH        (4),
        .LEAD_MARK_MIN (20'd400), .LEAD_MARK_MAX (20'd500),
        .LEAD_SPC_MIN  (20'd200), .LEAD_SPC_MAX  (20'd250),
        .REP_SPC_MIN   (20'd100), .REP_SPC_MAX   (20'd125),
        .BIT_MARK_MIN  (20'd20),  .BIT_MARK_MAX  (20'd36),
        .ZERO_SPC_MIN  (20'd20),  .ZERO_SPC_MAX  (20'd36),
        .ONE_SPC_MIN   (20'd70),  .ONE_SPC_MAX   (20'd100)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sfr_rd       (sfr_rd),
        .sfr_wr       (sfr_wr),
        .sfr_addr     (sfr_addr),
        .sfr_data_out (sfr_data_out),
        .sfr_data_in  (sfr_data_in),
        .IRDA_RXD     (irda_rxd),
        .ir_irq       (ir_irq)
    );

    // Monitor: every read strobe consumes one expected entry.
    always @(negedge clk) begin
        if (sfr_rd) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read got=%02h", sfr_data_in);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (sfr_data_in !== e.data || ir_irq !== e.irq) begin
                    failures++;
                    $display("FAIL %s got data=%02h irq=%b expected data=%02h irq=%b",
                             e.name, sfr_data_in, ir_irq, e.data, e.irq);
                end
            end
        end
    end

    task automatic sfr_read(input logic [7:0] a, input logic [7:0] d, input logic irq,
                            input string name);
        exp_q.push_back('{name, d, irq});
        sfr_addr = a;
        sfr_rd = 1'b1;
        @(posedge clk); #1;
        sfr_rd = 1'b0;
        sfr_addr = 8'h00;
    endtask

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        sfr_addr = a;
        sfr_data_out = d;
        sfr_wr = 1'b1;
        @(posedge clk); #1;
        sfr_wr = 1'b0;
        sfr_addr = 8'h00;
    endtask

    task automatic ir_hold(input logic lvl, input int n);
        irda_rxd = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] w);
        for (int i = 0; i < 32; i++) begin
            ir_hold(1'b0, 28);
            ir_hold(1'b1, w[i] ? 84 : 28);
        end
        ir_hold(1'b0, 28);
        ir_hold(1'b1, 60);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] an,
                              input logic [7:0] c, input logic [7:0] cn);
        ir_hold(1'b0, 450);
        ir_hold(1'b1, 225);
        send_bits({cn, c, an, a});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sfr_read(8'hE1, 8'h00, 1'b0, "reset_status");
        sfr_read(8'hE2, 8'h00, 1'b0, "reset_addr");
        sfr_read(8'hE5, 8'h00, 1'b0, "reset_cmd_n");

        // Basic frame
        sfr_write(8'hE1, 8'h80);
        send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3);
        sfr_read(8'hE1, 8'h81, 1'b0, "frame_status");
        sfr_read(8'hE2, 8'h5A, 1'b0, "frame_addr");
        sfr_read(8'hE3, 8'hA5, 1'b0, "frame_addr_n");
        sfr_read(8'hE4, 8'h3C, 1'b0, "frame_cmd");
        sfr_read(8'hE5, 8'hC3, 1'b0, "frame_cmd_n");
        sfr_read(8'hE6, 8'h00, 1'b0, "unmapped_read");
        sfr_write(8'hE2, 8'hFF);
        sfr_read(8'hE2, 8'h5A, 1'b0, "addr_write_ignored");
        sfr_write(8'hE1, 8'hC0);
        sfr_read(8'hE1, 8'hC1, 1'b1, "irq_enabled");
        sfr_write(8'hE1, 8'hC1);
        sfr_read(8'hE1, 8'hC0, 1'b0, "frame_cleared");

        // Repeat code
        ir_hold(1'b0, 450);
        ir_hold(1'b1, 112);
        ir_hold(1'b0, 28);
        ir_hold(1'b1, 60);
        sfr_read(8'hE1, 8'hC2, 1'b1, "repeat_status");
        sfr_read(8'hE2, 8'h5A, 1'b1, "repeat_addr_kept");
        sfr_read(8'hE4, 8'h3C, 1'b1, "repeat_cmd_kept");
        sfr_write(8'hE1, 8'hC2);

        // Checksum error
        send_frame(8'h5A, 8'h00, 8'h3C, 8'hC3);
        sfr_read(8'hE1, 8'hC4, 1'b0, "csum_status");
        sfr_read(8'hE3, 8'hA5, 1'b0, "csum_addr_n_kept");
        sfr_write(8'hE1, 8'hC4);

        // Glitches on idle line and inside the leader mark
        for (int k = 0; k < 4; k++) begin
            ir_hold(1'b0, 2);
            ir_hold(1'b1, 20);
        end
        sfr_read(8'hE1, 8'hC0, 1'b0, "glitch_idle_status");
        ir_hold(1'b0, 200);
        ir_hold(1'b1, 2);
        ir_hold(1'b0, 248);
        ir_hold(1'b1, 225);
        send_bits({8'h7E, 8'h81, 8'hCC, 8'h33});
        sfr_read(8'hE1, 8'hC1, 1'b1, "glitch_frame_status");
        sfr_read(8'hE2, 8'h33, 1'b1, "glitch_frame_addr");
        sfr_read(8'hE4, 8'h81, 1'b1, "glitch_frame_cmd");
        sfr_write(8'hE1, 8'hC1);

        // Overrun
        send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3);
        send_frame(8'h5A, 8'hA5, 8'h12, 8'hED);
        sfr_read(8'hE1, 8'hD1, 1'b1, "overrun_status");
        sfr_read(8'hE4, 8'h12, 1'b1, "overrun_cmd");
        sfr_read(8'hE5, 8'hED, 1'b1, "overrun_cmd_n");
        sfr_write(8'hE1, 8'hDF);
        sfr_read(8'hE1, 8'hC0, 1'b0, "overrun_cleared");

        // Abort on over-long leader mark
        ir_hold(1'b0, 600);
        ir_hold(1'b1, 60);
        sfr_read(8'hE1, 8'hC8, 1'b0, "abort_status");
        sfr_write(8'hE1, 8'hC8);

        // Asynchronous reset mid-frame
        sfr_write(8'hE1, 8'hC0);
        ir_hold(1'b0, 450);
        ir_hold(1'b1, 225);
        ir_hold(1'b0, 28);
        ir_hold(1'b1, 84);
        ir_hold(1'b0, 10);
        reset_n = 1'b0;
        irda_rxd = 1'b1;
        #3;
        sfr_read(8'hE1, 8'h00, 1'b0, "in_reset_status");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ir_hold(1'b1, 20);
        sfr_read(8'hE1, 8'h00, 1'b0, "post_reset_status");
        sfr_read(8'hE2, 8'h00, 1'b0, "post_reset_addr");
        sfr_read(8'hE4, 8'h00, 1'b0, "post_reset_cmd");
        sfr_write(8'hE1, 8'h80);
        send_frame(8'hA1, 8'h5E, 8'h07, 8'hF8);
        sfr_read(8'hE1, 8'h81, 1'b0, "after_reset_status");
        sfr_read(8'hE2, 8'hA1, 1'b0, "after_reset_addr");
        sfr_read(8'hE4, 8'h07, 1'b0, "after_reset_cmd");
        sfr_read(8'hE5, 8'hF8, 1'b0, "after_reset_cmd_n");

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
